// File: rtl/pbus_arbiter.sv
// Two-master peripheral bus arbiter: one-entry pending buffer per master, round-robin
// grant, one outstanding slave transaction, response routing and no-slave/timeout faults.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif

module pbus_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            m0_req,
  input  logic [`XLEN-1:0]                m0_addr,
  input  logic                            m0_w_rb,
  input  logic [$clog2(`BUS_ACC_CNT)-1:0] m0_acc,
  input  logic [`BUS_WIDTH-1:0]           m0_wdata,
  output logic                            m0_resp,
  output logic [`BUS_WIDTH-1:0]           m0_rdata,
  output logic                            m0_fault,
  input  logic                            m1_req,
  input  logic [`XLEN-1:0]                m1_addr,
  input  logic                            m1_w_rb,
  input  logic [$clog2(`BUS_ACC_CNT)-1:0] m1_acc,
  input  logic [`BUS_WIDTH-1:0]           m1_wdata,
  output logic                            m1_resp,
  output logic [`BUS_WIDTH-1:0]           m1_rdata,
  output logic                            m1_fault,
  output logic                            s_req,
  output logic [`XLEN-1:0]                s_addr,
  output logic                            s_w_rb,
  output logic [$clog2(`BUS_ACC_CNT)-1:0] s_acc,
  output logic [`BUS_WIDTH-1:0]           s_wdata,
  input  logic                            s_resp,
  input  logic [`BUS_WIDTH-1:0]           s_rdata,
  input  logic                            s_fault,
  output logic                            busy
);

  localparam int AW   = `XLEN;
  localparam int DW   = `BUS_WIDTH;
  localparam int ACCW = $clog2(`BUS_ACC_CNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [1:0]        w_req;
  logic [AW-1:0]     w_addr [2];
  logic [1:0]        w_w_rb;
  logic [ACCW-1:0]   w_acc [2];
  logic [DW-1:0]     w_wdata [2];

  logic [1:0]        r_pend_vld;
  logic [AW-1:0]     r_pend_addr [2];
  logic [1:0]        r_pend_w_rb;
  logic [ACCW-1:0]   r_pend_acc [2];
  logic [DW-1:0]     r_pend_wdata [2];

  logic              r_last_grant;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_s_req;
  logic [AW-1:0]     r_s_addr;
  logic              r_s_w_rb;
  logic [ACCW-1:0]   r_s_acc;
  logic [DW-1:0]     r_s_wdata;
  logic [1:0]        r_fault;
  logic [DW-1:0]     r_rdata [2];

  logic              w_grant;
  logic              w_do_grant;
  logic              w_resp;
  logic [1:0]        w_fault_nxt;
  logic [1:0]        w_active;
  logic [1:0]        w_capture;

  assign w_req      = {m1_req, m0_req};
  assign w_addr[0]  = m0_addr;
  assign w_addr[1]  = m1_addr;
  assign w_w_rb     = {m1_w_rb, m0_w_rb};
  assign w_acc[0]   = m0_acc;
  assign w_acc[1]   = m1_acc;
  assign w_wdata[0] = m0_wdata;
  assign w_wdata[1] = m1_wdata;

  // The owner of an in-flight transaction may not queue another request behind it.
  assign w_active[0] = (r_state != ST_IDLE) && !r_last_grant;
  assign w_active[1] = (r_state != ST_IDLE) &&  r_last_grant;
  assign w_capture   = w_req & ~r_pend_vld & ~w_active;

  // Pending request buffers: capture when empty, release on grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_vld  <= 2'b00;
      r_pend_w_rb <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_pend_addr[i]  <= '0;
        r_pend_acc[i]   <= '0;
        r_pend_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_capture[i]) begin
          r_pend_vld[i]   <= 1'b1;
          r_pend_addr[i]  <= w_addr[i];
          r_pend_w_rb[i]  <= w_w_rb[i];
          r_pend_acc[i]   <= w_acc[i];
          r_pend_wdata[i] <= w_wdata[i];
        end else if (w_do_grant && (w_grant == 1'(i))) begin
          r_pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Grant selection, transaction sequencing and response/fault decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = r_last_grant;
    w_do_grant  = 1'b0;
    w_resp      = 1'b0;
    w_fault_nxt = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_vld != 2'b00) begin
          w_do_grant  = 1'b1;
          w_state_nxt = ST_ISSUE;
          if (r_pend_vld == 2'b11) begin
            w_grant = ~r_last_grant;
          end else begin
            w_grant = r_pend_vld[1];
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (s_fault) begin
          w_fault_nxt[r_last_grant] = 1'b1;
          w_state_nxt               = ST_IDLE;
        end else if (s_resp) begin
          w_resp      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s_resp) begin
          w_resp      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_fault_nxt[r_last_grant] = 1'b1;
          w_state_nxt               = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant history, slave-side payload, wait counter and fault pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_s_req      <= 1'b0;
      r_s_addr     <= '0;
      r_s_w_rb     <= 1'b0;
      r_s_acc      <= '0;
      r_s_wdata    <= '0;
      r_fault      <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= w_fault_nxt;
      r_s_req <= w_do_grant;
      if (w_do_grant) begin
        r_last_grant <= w_grant;
        r_s_addr     <= r_pend_addr[w_grant];
        r_s_w_rb     <= r_pend_w_rb[w_grant];
        r_s_acc      <= r_pend_acc[w_grant];
        r_s_wdata    <= r_pend_wdata[w_grant];
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Last delivered read data per master, held while resp is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else if (w_resp) begin
      r_rdata[r_last_grant] <= s_rdata;
    end
  end

  assign m0_resp  = w_resp & ~r_last_grant;
  assign m1_resp  = w_resp &  r_last_grant;
  assign m0_rdata = m0_resp ? s_rdata : r_rdata[0];
  assign m1_rdata = m1_resp ? s_rdata : r_rdata[1];
  assign m0_fault = r_fault[0];
  assign m1_fault = r_fault[1];

  assign s_req   = r_s_req;
  assign s_addr  = r_s_addr;
  assign s_w_rb  = r_s_w_rb;
  assign s_acc   = r_s_acc;
  assign s_wdata = r_s_wdata;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pbus_arbiter.sv
// Directed bench for pbus_arbiter: a vector table of single transactions plus
// hand sequences for collisions, dropped requests and reset during WAIT.
module tb_pbus_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m0_w_rb, m0_resp, m0_fault;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_acc;
  logic        m1_req, m1_w_rb, m1_resp, m1_fault;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_acc;
  logic        s_req, s_w_rb, s_resp, s_fault, busy;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  s_acc;

  int          n_cmp = 0;
  int          n_bad = 0;

  // Slave model: responds slv_delay cycles after s_req (0 = same cycle, -1 = never).
  int          slv_delay;
  logic [31:0] slv_rdata;
  logic        force_resp;
  logic        slv_pend;
  int          slv_cnt;

  always #5 clk = ~clk;

  pbus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc),
    .m0_wdata(m0_wdata), .m0_resp(m0_resp), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc),
    .m1_wdata(m1_wdata), .m1_resp(m1_resp), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
    .s_req(s_req), .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata),
    .s_resp(s_resp), .s_rdata(s_rdata), .s_fault(s_fault), .busy(busy)
  );

  assign s_fault = s_req && (s_addr[31:16] == 16'hFFFF);
  assign s_rdata = slv_rdata;
  assign s_resp  = force_resp || (slv_pend && slv_cnt == 0) ||
                   (s_req && !s_fault && slv_delay == 0);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slv_pend <= 1'b0;
      slv_cnt  <= 0;
    end else if (s_req && !s_fault && slv_delay > 0) begin
      slv_pend <= 1'b1;
      slv_cnt  <= slv_delay - 1;
    end else if (slv_pend) begin
      if (slv_cnt == 0) slv_pend <= 1'b0;
      else slv_cnt <= slv_cnt - 1;
    end
  end

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        w;
    logic [1:0]  acc;
    logic [31:0] wd;
    int          delay;
    logic [31:0] rdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int m, input logic [31:0] a, input logic w,
                           input logic [1:0] acc, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = 1'b1; m0_addr = a; m0_w_rb = w; m0_acc = acc; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_addr = a; m1_w_rb = w; m1_acc = acc; m1_wdata = wd;
    end
  endtask

  task automatic clear_req();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int nreq = 0;
    int done_k = 0;
    logic got_resp = 1'b0;
    logic got_fault = 1'b0;
    logic other = 1'b0;
    logic own_resp, own_fault;
    logic [31:0] rd = 32'h0;
    slv_delay = v.delay;
    slv_rdata = v.rdata;
    @(negedge clk);
    drive_req(v.m, v.addr, v.w, v.acc, v.wd);
    for (int k = 1; k <= 30 && done_k == 0; k++) begin
      @(negedge clk);
      clear_req();
      if (s_req) begin
        nreq++;
        chk({tag, " issue_cycle"}, 32'(k), 32'd2);
        chk({tag, " s_addr"}, s_addr, v.addr);
        chk({tag, " s_ctl"}, {29'd0, s_w_rb, s_acc}, {29'd0, v.w, v.acc});
        chk({tag, " s_wdata"}, s_wdata, v.wd);
      end
      own_resp  = (v.m == 0) ? m0_resp  : m1_resp;
      own_fault = (v.m == 0) ? m0_fault : m1_fault;
      other     = other | ((v.m == 0) ? (m1_resp | m1_fault) : (m0_resp | m0_fault));
      if (own_resp) begin
        got_resp = 1'b1;
        done_k   = k;
        rd       = (v.m == 0) ? m0_rdata : m1_rdata;
      end
      if (own_fault) begin
        got_fault = 1'b1;
        done_k    = k;
      end
    end
    chk({tag, " s_req_count"}, 32'(nreq), 32'd1);
    chk({tag, " fault"}, 32'(got_fault), 32'(v.exp_fault));
    chk({tag, " resp"}, 32'(got_resp), 32'(!v.exp_fault));
    chk({tag, " latency"}, 32'(done_k), 32'(v.exp_lat));
    chk({tag, " non_owner_quiet"}, 32'(other), 32'd0);
    if (v.exp_fault) begin
      chk({tag, " busy_at_fault"}, 32'(busy), 32'd0);
    end else begin
      chk({tag, " rdata"}, rd, v.rdata);
      @(negedge clk);
      chk({tag, " busy_after"}, 32'(busy), 32'd0);
      chk({tag, " rdata_hold"}, (v.m == 0) ? m0_rdata : m1_rdata, v.rdata);
    end
    if (v.delay < 0) begin
      @(negedge clk);
      force_resp = 1'b1;
      #1;
      chk({tag, " stray_resp"}, {30'd0, m1_resp, m0_resp}, 32'd0);
      force_resp = 1'b0;
    end
  endtask

  task automatic collide(input int first, input string tag);
    int seen = 0;
    int r0k = 0;
    int r1k = 0;
    slv_delay = 0;
    slv_rdata = 32'h5A5A_0000;
    @(negedge clk);
    drive_req(0, 32'h0000_0100, 1'b0, 2'd2, 32'h0);
    drive_req(1, 32'h0000_0200, 1'b1, 2'd2, 32'h0000_BEEF);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      clear_req();
      if (s_req) begin
        seen++;
        if (seen == 1) begin
          chk({tag, " first_addr"}, s_addr, (first == 0) ? 32'h0000_0100 : 32'h0000_0200);
          chk({tag, " first_cycle"}, 32'(k), 32'd2);
        end else begin
          chk({tag, " second_addr"}, s_addr, (first == 0) ? 32'h0000_0200 : 32'h0000_0100);
          chk({tag, " second_cycle"}, 32'(k), 32'd4);
        end
      end
      if (m0_resp) r0k = k;
      if (m1_resp) r1k = k;
    end
    chk({tag, " grants"}, 32'(seen), 32'd2);
    chk({tag, " m0_resp_cycle"}, 32'(r0k), (first == 0) ? 32'd2 : 32'd4);
    chk({tag, " m1_resp_cycle"}, 32'(r1k), (first == 0) ? 32'd4 : 32'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    int nresp;
    int rk;
    int late;
    vec_t v;

    tbl[0] = '{0, 32'h0000_1004, 1'b0, 2'd2, 32'h0000_0000, 3,  32'hDEAD_BEEF, 1'b0, 5};
    tbl[1] = '{1, 32'h0000_2000, 1'b1, 2'd2, 32'h1234_5678, 0,  32'hCAFE_0001, 1'b0, 2};
    tbl[2] = '{1, 32'hFFFF_0000, 1'b0, 2'd2, 32'h0000_0000, 0,  32'h0000_0000, 1'b1, 3};
    tbl[3] = '{0, 32'h0000_3000, 1'b0, 2'd2, 32'h0000_0000, -1, 32'h0000_0000, 1'b1, 11};
    tbl[4] = '{0, 32'h0000_0010, 1'b1, 2'd0, 32'h0000_00A5, 1,  32'h0BAD_0004, 1'b0, 3};
    tbl[5] = '{1, 32'h0000_0020, 1'b0, 2'd1, 32'h0000_0000, 7,  32'h55AA_0005, 1'b0, 9};
    tbl[6] = '{0, 32'h0000_0030, 1'b0, 2'd2, 32'h0000_0000, 8,  32'h7777_0006, 1'b0, 10};

    rstn = 1'b0;
    force_resp = 1'b0;
    slv_delay = -1;
    slv_rdata = 32'h0;
    clear_req();
    m0_addr = 32'h0; m0_w_rb = 1'b0; m0_acc = 2'd0; m0_wdata = 32'h0;
    m1_addr = 32'h0; m1_w_rb = 1'b0; m1_acc = 2'd0; m1_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset ctrl", {26'd0, busy, s_req, m0_resp, m0_fault, m1_resp, m1_fault}, 32'd0);
    chk("reset s_addr", s_addr, 32'd0);
    chk("reset s_wdata", s_wdata, 32'd0);
    chk("reset m0_rdata", m0_rdata, 32'd0);
    chk("reset m1_rdata", m1_rdata, 32'd0);

    collide(0, "collide1");

    for (int i = 0; i < 7; i++) begin
      v = tbl[i];
      run_txn(v, $sformatf("vec%0d", i));
    end

    collide(1, "collide2");

    // Second m0 request while m0 owns the bus in WAIT must vanish.
    slv_delay = 5;
    slv_rdata = 32'h1111_2222;
    nreq = 0; nresp = 0; rk = 0;
    @(negedge clk);
    drive_req(0, 32'h0000_0400, 1'b0, 2'd2, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      clear_req();
      if (s_req) nreq++;
      if (m0_resp) begin
        nresp++;
        rk = k;
      end
      if (k == 4) begin
        $display("note: m0_req issued while m0 owns the bus (protocol violation, expect drop)");
        drive_req(0, 32'h0000_0500, 1'b0, 2'd2, 32'h0);
      end
    end
    chk("drop s_req_count", 32'(nreq), 32'd1);
    chk("drop m0_resp_count", 32'(nresp), 32'd1);
    chk("drop resp_cycle", 32'(rk), 32'd7);

    // Reset asserted while m0 waits on a silent slave.
    slv_delay = -1;
    @(negedge clk);
    drive_req(0, 32'h0000_0600, 1'b1, 2'd2, 32'h0000_0066);
    repeat (4) begin
      @(negedge clk);
      clear_req();
    end
    chk("rst busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst ctrl_async", {26'd0, busy, s_req, m0_resp, m0_fault, m1_resp, m1_fault}, 32'd0);
    chk("rst s_addr_async", s_addr, 32'd0);
    chk("rst s_wdata_async", s_wdata, 32'd0);
    chk("rst m0_rdata_async", m0_rdata, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    late = 0;
    repeat (12) begin
      @(negedge clk);
      late += int'(m0_fault | m0_resp | s_req | busy);
    end
    chk("rst no_late_activity", 32'(late), 32'd0);
    v = '{1, 32'h0000_0700, 1'b0, 2'd2, 32'h0, 2, 32'h0F0F_0707, 1'b0, 4};
    run_txn(v, "post_rst_m1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
